// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage.
//   fetch_state_e    : fetch controller states
//   NOP_INSTR        : bubble instruction word (decodes as a no-op)
//   RESET_PC_DEFAULT : default reset fetch address
package fetch_pkg;

    typedef enum logic [1:0] {
        StFetch = 2'd0,
        StDrain = 2'd1,
        StHold  = 2'd2
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/fetch_target_gen.sv
// Redirect target generator (purely combinational).
//   pc4_i    : PC+4 of the redirecting instruction
//   imm_i    : branch immediate in signed words
//   idx_i    : jump instruction index
//   jump_i   : select the jump target instead of the branch target
//   target_o : redirect target address
module fetch_target_gen (
    input  logic [31:0] pc4_i,
    input  logic [15:0] imm_i,
    input  logic [25:0] idx_i,
    input  logic        jump_i,
    output logic [31:0] target_o
);

    logic [31:0] branch_target;
    logic [31:0] jump_target;

    // Word offset sign-extended and scaled to bytes; the add wraps modulo 2^32.
    assign branch_target = pc4_i + {{14{imm_i[15]}}, imm_i, 2'b00};
    assign jump_target   = {pc4_i[31:28], idx_i, 2'b00};
    assign target_o      = jump_i ? jump_target : branch_target;

endmodule

// File: rtl/instr_fetch_stage.sv
// Instruction fetch stage with IF/ID pipeline register.
//   clk_in, rst_n_in                 : clock, synchronous active-low reset
//   stall_in                         : hold IF/ID contents
//   branch_taken_in, jump_in         : redirect requests from downstream
//   redirect_pc4_in, branch_imm_in,
//   jump_idx_in                      : redirect target operands
//   imem_req_out, imem_addr_out      : instruction memory request
//   imem_ready_in, imem_rdata_in     : instruction memory response
//   instr_out, pc4_out, valid_out    : IF/ID register
//   op_out, func_out                 : opcode / function fields of instr_out
module instr_fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        stall_in,
    input  logic        branch_taken_in,
    input  logic        jump_in,
    input  logic [31:0] redirect_pc4_in,
    input  logic [15:0] branch_imm_in,
    input  logic [25:0] jump_idx_in,
    output logic        imem_req_out,
    output logic [31:0] imem_addr_out,
    input  logic        imem_ready_in,
    input  logic [31:0] imem_rdata_in,
    output logic [31:0] instr_out,
    output logic [31:0] pc4_out,
    output logic        valid_out,
    output logic [5:0]  op_out,
    output logic [5:0]  func_out
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  drain_addr_q, drain_addr_d;
    logic [31:0]  buf_instr_q, buf_instr_d;
    logic [31:0]  buf_pc4_q, buf_pc4_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  pc4_q, pc4_d;
    logic         valid_q, valid_d;

    logic [31:0]  target;
    logic [31:0]  pc_plus4;
    logic         redirect;

    fetch_target_gen u_target_gen (
        .pc4_i    (redirect_pc4_in),
        .imm_i    (branch_imm_in),
        .idx_i    (jump_idx_in),
        .jump_i   (jump_in),
        .target_o (target)
    );

    assign redirect = branch_taken_in | jump_in;
    assign pc_plus4 = pc_q + 32'd4;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        drain_addr_d = drain_addr_q;
        buf_instr_d  = buf_instr_q;
        buf_pc4_d    = buf_pc4_q;
        instr_d      = instr_q;
        pc4_d        = pc4_q;
        valid_d      = valid_q;

        if (redirect) begin
            // Redirect overrides stall: squash IF/ID and drop any buffered fetch.
            instr_d     = NOP_INSTR;
            valid_d     = 1'b0;
            buf_instr_d = '0;
            buf_pc4_d   = '0;
            pc_d        = target;
            case (state_q)
                StFetch: begin
                    // An unanswered request must still complete at its old address.
                    if (!imem_ready_in) begin
                        state_d      = StDrain;
                        drain_addr_d = pc_q;
                    end
                end
                StDrain: begin
                    if (imem_ready_in) begin
                        state_d = StFetch;
                    end
                end
                default: state_d = StFetch;
            endcase
        end else begin
            case (state_q)
                StFetch: begin
                    if (stall_in) begin
                        if (imem_ready_in) begin
                            buf_instr_d = imem_rdata_in;
                            buf_pc4_d   = pc_plus4;
                            pc_d        = pc_plus4;
                            state_d     = StHold;
                        end
                    end else if (imem_ready_in) begin
                        instr_d = imem_rdata_in;
                        pc4_d   = pc_plus4;
                        valid_d = 1'b1;
                        pc_d    = pc_plus4;
                    end else begin
                        instr_d = NOP_INSTR;
                        valid_d = 1'b0;
                    end
                end
                StDrain: begin
                    if (imem_ready_in) begin
                        state_d = StFetch;
                    end
                end
                StHold: begin
                    if (!stall_in) begin
                        instr_d = buf_instr_q;
                        pc4_d   = buf_pc4_q;
                        valid_d = 1'b1;
                        state_d = StFetch;
                    end
                end
                default: state_d = StFetch;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state_q      <= StFetch;
            pc_q         <= RESET_PC;
            drain_addr_q <= '0;
            buf_instr_q  <= '0;
            buf_pc4_q    <= '0;
            instr_q      <= NOP_INSTR;
            pc4_q        <= '0;
            valid_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            drain_addr_q <= drain_addr_d;
            buf_instr_q  <= buf_instr_d;
            buf_pc4_q    <= buf_pc4_d;
            instr_q      <= instr_d;
            pc4_q        <= pc4_d;
            valid_q      <= valid_d;
        end
    end

    // Request is gated by reset so an in-flight fetch is abandoned immediately.
    assign imem_req_out  = rst_n_in && (state_q != StHold);
    assign imem_addr_out = (state_q == StDrain) ? drain_addr_q : pc_q;

    assign instr_out = instr_q;
    assign pc4_out   = pc4_q;
    assign valid_out = valid_q;
    assign op_out    = instr_q[31:26];
    assign func_out  = instr_q[5:0];

endmodule

// File: tb/tb_instr_fetch_stage.sv
module tb_instr_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic        stall_in;
    logic        branch_taken_in;
    logic        jump_in;
    logic [31:0] redirect_pc4_in;
    logic [15:0] branch_imm_in;
    logic [25:0] jump_idx_in;
    logic        imem_req_out;
    logic [31:0] imem_addr_out;
    logic        imem_ready_in;
    logic [31:0] imem_rdata_in;
    logic [31:0] instr_out;
    logic [31:0] pc4_out;
    logic        valid_out;
    logic [5:0]  op_out;
    logic [5:0]  func_out;

    always #5 clk_in = ~clk_in;

    instr_fetch_stage #(.RESET_PC(RST_PC)) dut (
        .clk_in          (clk_in),
        .rst_n_in        (rst_n_in),
        .stall_in        (stall_in),
        .branch_taken_in (branch_taken_in),
        .jump_in         (jump_in),
        .redirect_pc4_in (redirect_pc4_in),
        .branch_imm_in   (branch_imm_in),
        .jump_idx_in     (jump_idx_in),
        .imem_req_out    (imem_req_out),
        .imem_addr_out   (imem_addr_out),
        .imem_ready_in   (imem_ready_in),
        .imem_rdata_in   (imem_rdata_in),
        .instr_out       (instr_out),
        .pc4_out         (pc4_out),
        .valid_out       (valid_out),
        .op_out          (op_out),
        .func_out        (func_out)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: fetch pointer, outstanding-discard flag with its address,
    // a queue of instructions parked while stalled, and the IF/ID contents.
    logic [31:0] m_pc;
    bit          m_discard;
    logic [31:0] m_discard_addr;
    logic [63:0] m_parked[$];
    logic [31:0] m_instr;
    logic [31:0] m_pc4;
    bit          m_valid;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        bit exp_req;
        exp_req = (rst_n_in === 1'b1) && (m_parked.size() == 0);
        chk("req", {31'b0, imem_req_out}, {31'b0, exp_req});
        if (exp_req) chk("addr", imem_addr_out, m_discard ? m_discard_addr : m_pc);
        chk("valid", {31'b0, valid_out}, {31'b0, m_valid});
        chk("instr", instr_out, m_instr);
        chk("op", {26'b0, op_out}, {26'b0, m_instr[31:26]});
        chk("func", {26'b0, func_out}, {26'b0, m_instr[5:0]});
        if (m_valid) chk("pc4", pc4_out, m_pc4);
    endtask

    task automatic model_step();
        logic [31:0] tgt;
        int signed   off;
        if (!rst_n_in) begin
            m_pc = RST_PC; m_discard = 0; m_parked.delete();
            m_instr = 0; m_pc4 = 0; m_valid = 0;
        end else if (branch_taken_in || jump_in) begin
            off = 32'($signed(branch_imm_in)) * 4;
            tgt = jump_in ? {redirect_pc4_in[31:28], jump_idx_in, 2'b00}
                          : redirect_pc4_in + 32'(off);
            m_instr = 0; m_valid = 0;
            if (m_discard) begin
                if (imem_ready_in) m_discard = 0;
            end else if (m_parked.size() == 0 && !imem_ready_in) begin
                m_discard = 1; m_discard_addr = m_pc;
            end
            m_parked.delete();
            m_pc = tgt;
        end else if (m_discard) begin
            if (imem_ready_in) m_discard = 0;
        end else if (m_parked.size() != 0) begin
            if (!stall_in) begin
                {m_instr, m_pc4} = m_parked.pop_front();
                m_valid = 1;
            end
        end else if (stall_in) begin
            if (imem_ready_in) begin
                m_parked.push_back({imem_rdata_in, m_pc + 32'd4});
                m_pc = m_pc + 4;
            end
        end else if (imem_ready_in) begin
            m_instr = imem_rdata_in; m_pc4 = m_pc + 4; m_valid = 1; m_pc = m_pc + 4;
        end else begin
            m_instr = 0; m_valid = 0;
        end
    endtask

    task automatic cycle();
        @(negedge clk_in);
        check_outputs();
        @(posedge clk_in);
        model_step();
        #1;
    endtask

    task automatic drive(input bit rst_n, input bit stall, input bit br, input bit jmp,
                         input bit rdy);
        rst_n_in = rst_n; stall_in = stall; branch_taken_in = br; jump_in = jmp;
        imem_ready_in = rdy; imem_rdata_in = $urandom;
        redirect_pc4_in = $urandom; branch_imm_in = 16'($urandom); jump_idx_in = 26'($urandom);
    endtask

    initial begin
        logic [31:0] old_addr;
        drive(0, 0, 0, 0, 0);
        @(posedge clk_in);
        model_step();
        #1;
        // Reset state
        repeat (2) cycle();

        // Zero-wait memory, no stall
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 0, 0, 1);
            cycle();
        end

        // Memory ready every third cycle
        for (int i = 0; i < 9; i++) begin
            drive(1, 0, 0, 0, (i % 3) == 2);
            cycle();
        end

        // Stall for three cycles while a fetch returns
        drive(1, 1, 0, 0, 1);
        imem_rdata_in = 32'h8C01_0004;
        cycle();
        repeat (2) begin
            drive(1, 1, 0, 0, 0);
            cycle();
        end
        drive(1, 0, 0, 0, 0);
        cycle();
        chk("stall_release_instr", instr_out, 32'h8C01_0004);

        // Branch while memory not ready -> drain at old address
        old_addr = m_pc;
        drive(1, 0, 1, 0, 0);
        redirect_pc4_in = 32'h0000_0100;
        branch_imm_in   = 16'hFFFE;
        cycle();
        repeat (2) begin
            drive(1, 0, 0, 0, 0);
            cycle();
            chk("drain_addr", imem_addr_out, old_addr);
        end
        drive(1, 0, 0, 0, 1);
        cycle();
        chk("branch_target", imem_addr_out, 32'h0000_00F8);
        chk("drain_not_valid", {31'b0, valid_out}, 32'd0);

        // Jump and branch together under stall
        drive(1, 1, 1, 1, 1);
        redirect_pc4_in = 32'h9000_0010;
        jump_idx_in     = 26'h000_0040;
        cycle();
        chk("jump_target", imem_addr_out, 32'h9000_0100);
        chk("jump_bubble", {31'b0, valid_out}, 32'd0);

        // Reset during drain
        drive(1, 0, 1, 0, 0);
        cycle();
        drive(0, 0, 0, 0, 0);
        cycle();
        drive(1, 0, 0, 0, 0);
        #1;
        chk("post_reset_req", {31'b0, imem_req_out}, 32'd1);
        chk("post_reset_addr", imem_addr_out, RST_PC);
        cycle();

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(63) != 0), ($urandom_range(3) == 0),
                  ($urandom_range(11) == 0), ($urandom_range(15) == 0),
                  ($urandom_range(1) == 0));
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
